// File: rtl/mem_pkg.sv
// Shared types and request checks for the multicycle memory responder.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BAD} op_t;

    localparam int unsigned WORD_BYTES = 4;

    // A request faults if it is misaligned, beyond the array, or both read and write.
    function automatic logic req_fault(input logic [31:0] addr, input logic rd, input logic wr,
                                       input int unsigned depth);
        logic [31:0] word;
        word = addr / WORD_BYTES;
        return (addr[1:0] != 2'b00) || (word >= depth) || (rd && wr);
    endfunction

    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return OP_BAD;
        end else if (wr) begin
            return OP_WRITE;
        end
        return OP_READ;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM with write enable and a registered, enabled read port. No reset.
module mem_word_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder: accepts one request, waits LATENCY edges, then pulses ready
// (with err on faulted requests) for one cycle.
module mem_wait_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_wait_responder: LATENCY must be at least 1");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    op_t                op;
    logic               fault;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  wdata_q;
    logic               rvalid;
    logic               commit;
    logic               ram_we;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_rdata;

    // The edge leaving WAIT with cnt==0 is the commit edge, LATENCY edges after acceptance.
    always_comb begin
        commit = (state == WAIT) && (cnt == '0);
        ram_we = commit && (op == OP_WRITE) && !fault;
        ram_re = commit && (op == OP_READ) && !fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= OP_READ;
            fault   <= 1'b0;
            idx     <= '0;
            wdata_q <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (mem_read || mem_write) begin
                        state   <= WAIT;
                        busy    <= 1'b1;
                        cnt     <= CNT_W'(LATENCY - 1);
                        op      <= decode_op(mem_read, mem_write);
                        fault   <= req_fault(addr, mem_read, mem_write, DEPTH);
                        idx     <= addr[2 +: IDX_W];
                        wdata_q <= wdata;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESPOND;
                        ready <= 1'b1;
                        err   <= fault;
                        // Faulted transactions force rdata to zero until the next good read.
                        if (fault) begin
                            rvalid <= 1'b0;
                        end else if (op == OP_READ) begin
                            rvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_word_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (idx),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign rdata = rvalid ? ram_rdata : '0;

endmodule
